// File: rtl/rv32i_types.sv
// ============================================================================
// Module : rv32i_types
// Shared fetch-path types: word type, fetch FSM encoding, FIFO entry record.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_BUSY   = 2'd1,
        FS_SQUASH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_entry_t;

    function automatic rv32i_word word_align(input rv32i_word addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Circular FIFO of {pc, instr} entries with head/tail pointers and count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_push,
    input  fetch_entry_t    i_entry,
    input  logic            i_pop,
    output fetch_entry_t    o_head,
    output logic [CW-1:0]   o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module : fetch_buffer
// Instruction fetch FSM feeding decode through a small FIFO, with redirect.
// Optional macro FETCH_BUF_BYPASS_EN: response passes straight to decode
// when the FIFO is empty.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_buffer
    import rv32i_types::*;
#(
    parameter int        DEPTH    = 4,
    parameter rv32i_word RESET_PC = 32'h6000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       imem_read,
    output rv32i_word  imem_addr,
    input  logic       imem_resp,
    input  rv32i_word  imem_rdata,
    input  logic       redirect_valid,
    input  rv32i_word  redirect_pc,
    output logic       dec_valid,
    input  logic       dec_ready,
    output rv32i_word  dec_instr,
    output rv32i_word  dec_pc
);

    localparam int            CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_FULL_CNT = CW'(DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    rv32i_word     r_fetch_pc;
    rv32i_word     w_fetch_pc_nxt;
    rv32i_word     r_req_addr;
    logic          w_new_req;
    logic          w_resp_ok;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_cnt_nxt;
    fetch_entry_t  w_head;
    fetch_entry_t  w_entry;

    assign w_resp_ok = (r_state == FS_BUSY) && imem_resp && !redirect_valid;
    assign w_empty   = (w_count == '0);

`ifdef FETCH_BUF_BYPASS_EN
    assign w_bypass = w_resp_ok && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop     = !w_empty && dec_ready && !redirect_valid;
    assign w_push    = w_resp_ok && !(w_bypass && dec_ready);
    assign w_cnt_nxt = w_count + CW'(w_push) - CW'(w_pop);
    assign w_entry   = '{pc: r_fetch_pc, instr: imem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // r_fetch_pc may move on in SQUASH while the old request is still held.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_new_req      = 1'b0;
        if (redirect_valid) begin
            w_fetch_pc_nxt = word_align(redirect_pc);
        end
        case (r_state)
            FS_IDLE: begin
                if (redirect_valid || (w_cnt_nxt < c_FULL_CNT)) begin
                    w_state_nxt = FS_BUSY;
                    w_new_req   = 1'b1;
                end
            end
            FS_BUSY: begin
                if (redirect_valid) begin
                    if (imem_resp) begin
                        w_new_req = 1'b1;
                    end else begin
                        w_state_nxt = FS_SQUASH;
                    end
                end else if (imem_resp) begin
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    if (w_cnt_nxt < c_FULL_CNT) begin
                        w_new_req = 1'b1;
                    end else begin
                        w_state_nxt = FS_IDLE;
                    end
                end
            end
            FS_SQUASH: begin
                if (imem_resp) begin
                    w_state_nxt = FS_BUSY;
                    w_new_req   = 1'b1;
                end
            end
            default: w_state_nxt = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FS_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            if (w_new_req) begin
                r_req_addr <= w_fetch_pc_nxt;
            end
        end
    end

    assign imem_read = (r_state != FS_IDLE);
    assign imem_addr = r_req_addr;
    assign dec_valid = (!w_empty || w_bypass) && !redirect_valid;
    assign dec_pc    = w_bypass ? r_fetch_pc : w_head.pc;
    assign dec_instr = w_bypass ? imem_rdata : w_head.instr;

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ============================================================================
// Module : tb_fetch_buffer
// Directed table-driven bench for fetch_buffer plus multi-cycle sequences.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_buffer;

    localparam logic [31:0] R = 32'h6000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic        imem_resp = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_buffer #(.DEPTH(4), .RESET_PC(R)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_read      (imem_read),
        .imem_addr      (imem_addr),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          resp;
        logic [31:0] rdata;
        bit          redir;
        logic [31:0] rpc;
        bit          rdy;
        bit          e_read;
        logic [31:0] e_addr;
        bit          e_dv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(bit rst, bit resp, logic [31:0] rdata, bit redir,
                                logic [31:0] rpc, bit rdy, bit e_read,
                                logic [31:0] e_addr, bit e_dv, logic [31:0] e_pc,
                                logic [31:0] e_instr);
        vec_t v;
        v.rst = rst; v.resp = resp; v.rdata = rdata; v.redir = redir;
        v.rpc = rpc; v.rdy = rdy; v.e_read = e_read; v.e_addr = e_addr;
        v.e_dv = e_dv; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input bit rst, input bit resp, input logic [31:0] rdata,
                         input bit redir, input logic [31:0] rpc, input bit rdy);
        @(negedge clk);
        rst_n          = !rst;
        imem_resp      = resp;
        imem_rdata     = rdata;
        redirect_valid = redir;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        #1;
    endtask

    task automatic chk_out(input string tag, input bit e_read, input logic [31:0] e_addr,
                           input bit e_dv, input logic [31:0] e_pc, input logic [31:0] e_instr);
        chk({tag, " imem_read"}, 32'(imem_read), 32'(e_read));
        if (e_read) chk({tag, " imem_addr"}, imem_addr, e_addr);
        chk({tag, " dec_valid"}, 32'(dec_valid), 32'(e_dv));
        if (e_dv) begin
            chk({tag, " dec_pc"}, dec_pc, e_pc);
            chk({tag, " dec_instr"}, dec_instr, e_instr);
        end
    endtask

    initial begin
        // In-order stream, memory answers on the second request cycle
        tbl[0]  = mk(1, 0, 0, 0, 0, 1,   0, 0,      0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1,   0, 0,      0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1,   1, R,      0, 0, 0);
        tbl[3]  = mk(0, 1, 32'hA000_0000, 0, 0, 1,   1, R, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1,   1, R+4,    1, R, 32'hA000_0000);
        tbl[5]  = mk(0, 1, 32'hA000_0001, 0, 0, 1,   1, R+4, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1,   1, R+8,    1, R+4, 32'hA000_0001);
        tbl[7]  = mk(0, 1, 32'hA000_0002, 0, 0, 1,   1, R+8, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1,   1, R+12,   1, R+8, 32'hA000_0002);
        // Fill to DEPTH with decode stalled, then one dequeue restarts fetch
        tbl[9]  = mk(1, 0, 0, 0, 0, 0,   0, 0,      0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0,   0, 0,      0, 0, 0);
        tbl[11] = mk(0, 1, 32'hB000_0000, 0, 0, 0,   1, R,    0, 0, 0);
        tbl[12] = mk(0, 1, 32'hB000_0001, 0, 0, 0,   1, R+4,  1, R, 32'hB000_0000);
        tbl[13] = mk(0, 1, 32'hB000_0002, 0, 0, 0,   1, R+8,  1, R, 32'hB000_0000);
        tbl[14] = mk(0, 1, 32'hB000_0003, 0, 0, 0,   1, R+12, 1, R, 32'hB000_0000);
        tbl[15] = mk(0, 0, 0, 0, 0, 0,   0, 0,      1, R, 32'hB000_0000);
        tbl[16] = mk(0, 0, 0, 0, 0, 1,   0, 0,      1, R, 32'hB000_0000);
        tbl[17] = mk(0, 0, 0, 0, 0, 0,   1, R+16,   1, R+4, 32'hB000_0001);
        // Redirect to unaligned 0x103 while waiting; late response squashed
        tbl[18] = mk(1, 0, 0, 0, 0, 0,   0, 0,      0, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0,   0, 0,      0, 0, 0);
        tbl[20] = mk(0, 0, 0, 1, 32'h103, 0,   1, R, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0,   1, R,      0, 0, 0);
        tbl[22] = mk(0, 1, 32'hC000_0000, 0, 0, 0,   1, R, 0, 0, 0);
        tbl[23] = mk(0, 0, 0, 0, 0, 0,   1, 32'h100, 0, 0, 0);
        tbl[24] = mk(0, 1, 32'hC000_0001, 0, 0, 0,   1, 32'h100, 0, 0, 0);
        tbl[25] = mk(0, 0, 0, 0, 0, 0,   1, 32'h104, 1, 32'h100, 32'hC000_0001);
        // Redirect coincident with response and dec_ready
        tbl[26] = mk(0, 1, 32'hC000_0002, 1, 32'h200, 1,   1, 32'h104, 0, 0, 0);
        tbl[27] = mk(0, 0, 0, 0, 0, 1,   1, 32'h200, 0, 0, 0);

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].rst, tbl[i].resp, tbl[i].rdata, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
            chk_out($sformatf("row%0d", i), tbl[i].e_read, tbl[i].e_addr,
                    tbl[i].e_dv, tbl[i].e_pc, tbl[i].e_instr);
        end

        // Reset mid-request (outstanding at 0x200), stale response after release
        drive(1, 0, 0, 0, 0, 0);
        chk_out("rst_mid", 0, 0, 0, 0, 0);
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk_out("stale_resp", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_out("first_after_rst", 1, R, 0, 0, 0);
        drive(0, 1, 32'hE000_0000, 0, 0, 0);
        chk_out("resp_e0", 1, R, 0, 0, 0);

        // Redirect into SQUASH, then a second redirect while squashing
        drive(0, 0, 0, 1, 32'h300, 0);
        chk_out("redir_a", 1, R+4, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h404, 0);
        chk_out("redir_in_squash", 1, R+4, 0, 0, 0);
        drive(0, 1, 32'hE000_0001, 0, 0, 0);
        chk_out("squash_resp", 1, R+4, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_out("after_squash", 1, 32'h404, 0, 0, 0);

        // Response-to-decode latency with an empty FIFO
        drive(0, 1, 32'hF000_0000, 0, 0, 1);
`ifdef FETCH_BUF_BYPASS_EN
        chk_out("bypass_same", 1, 32'h404, 1, 32'h404, 32'hF000_0000);
        drive(0, 0, 0, 0, 0, 1);
        chk_out("bypass_next", 1, 32'h408, 0, 0, 0);
`else
        chk_out("lat_same", 1, 32'h404, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        chk_out("lat_next", 1, 32'h408, 1, 32'h404, 32'hF000_0000);
`endif

        // Redirect in IDLE right after reset release
        drive(1, 0, 0, 0, 0, 0);
        chk_out("rst_again", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h5FF, 0);
        chk_out("idle_redir", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_out("idle_redir_fetch", 1, 32'h5FC, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
